// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iir_pkg
// Purpose  : Shared types and constants for the biquad coefficient loader.
// Revision : 1.0
// ============================================================================
package iir_pkg;

    localparam int              COEFF_W          = 16;
    localparam logic [15:0]     UNITY            = 16'h7FFF;
    localparam int              COEFFS_PER_STAGE = 5;
    localparam int              SLOT_W           = 3;

    typedef struct packed {
        logic [COEFF_W-1:0] b0;
        logic [COEFF_W-1:0] b1;
        logic [COEFF_W-1:0] b2;
        logic [COEFF_W-1:0] a1;
        logic [COEFF_W-1:0] a2;
    } coeff_set_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PENDING = 2'd2
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/iir_coeff_bank.sv
`default_nettype none
// ============================================================================
// Module   : iir_coeff_bank
// Purpose  : Shadow/active coefficient register pair for one biquad stage.
// Revision : 1.0
// ============================================================================
module iir_coeff_bank #(
    parameter int                 COEFF_W = iir_pkg::COEFF_W,
    parameter logic [COEFF_W-1:0] UNITY   = iir_pkg::UNITY
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_wr_en,
    input  logic [iir_pkg::SLOT_W-1:0]    i_wr_slot,
    input  logic [COEFF_W-1:0]            i_wr_data,
    input  logic                          i_commit,
    output logic [COEFF_W-1:0]            o_b0,
    output logic [COEFF_W-1:0]            o_b1,
    output logic [COEFF_W-1:0]            o_b2,
    output logic [COEFF_W-1:0]            o_a1,
    output logic [COEFF_W-1:0]            o_a2
);
    import iir_pkg::*;

    localparam int C_SLOTS = COEFFS_PER_STAGE;
    // Slot 0 (b0) resets to unity so an unconfigured stage passes audio through.
    localparam logic [C_SLOTS-1:0][COEFF_W-1:0] C_RESET_SET =
        {{((C_SLOTS-1)*COEFF_W){1'b0}}, UNITY};

    logic [C_SLOTS-1:0][COEFF_W-1:0] r_shadow_q;
    logic [C_SLOTS-1:0][COEFF_W-1:0] w_shadow_d;
    logic [C_SLOTS-1:0][COEFF_W-1:0] r_active_q;
    logic [C_SLOTS-1:0][COEFF_W-1:0] w_active_d;

    always_comb begin
        w_shadow_d = r_shadow_q;
        w_active_d = r_active_q;
        if (i_wr_en) begin
            w_shadow_d[i_wr_slot] = i_wr_data;
        end
        if (i_commit) begin
            w_active_d = r_shadow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_q <= C_RESET_SET;
            r_active_q <= C_RESET_SET;
        end else begin
            r_shadow_q <= w_shadow_d;
            r_active_q <= w_active_d;
        end
    end

    assign o_b0 = r_active_q[0];
    assign o_b1 = r_active_q[1];
    assign o_b2 = r_active_q[2];
    assign o_a1 = r_active_q[3];
    assign o_a2 = r_active_q[4];

endmodule
`default_nettype wire

// File: rtl/iir_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : iir_coeff_loader
// Purpose  : Word-serial coefficient loader with atomic sample-aligned commit.
// Revision : 1.0
// ============================================================================
module iir_coeff_loader #(
    parameter int                 NUM_STAGES = 2,
    parameter int                 COEFF_W    = iir_pkg::COEFF_W,
    parameter logic [COEFF_W-1:0] UNITY      = iir_pkg::UNITY
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [COEFF_W-1:0]             cfg_data,
    input  logic                           cfg_last,
    input  logic                           cfg_abort,
    input  logic                           sample_tick,
    output logic [NUM_STAGES*COEFF_W-1:0]  coeff_b0,
    output logic [NUM_STAGES*COEFF_W-1:0]  coeff_b1,
    output logic [NUM_STAGES*COEFF_W-1:0]  coeff_b2,
    output logic [NUM_STAGES*COEFF_W-1:0]  coeff_a1,
    output logic [NUM_STAGES*COEFF_W-1:0]  coeff_a2,
    output logic                           pending,
    output logic                           commit_done,
    output logic                           load_err
);
    import iir_pkg::*;

    localparam int                    C_STAGE_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [C_STAGE_W-1:0]  C_LAST_STAGE = C_STAGE_W'(NUM_STAGES - 1);
    localparam logic [SLOT_W-1:0]     C_LAST_SLOT  = SLOT_W'(COEFFS_PER_STAGE - 1);

    loader_state_t           r_state_q, w_state_d;
    // Word index kept as (stage, slot) so no divider is needed for addressing.
    logic [C_STAGE_W-1:0]    r_stage_q, w_stage_d;
    logic [SLOT_W-1:0]       r_slot_q,  w_slot_d;
    logic                    r_commit_done_q, w_commit_done_d;
    logic                    r_load_err_q,    w_load_err_d;
    logic                    w_wr_en;
    logic                    w_commit;
    logic                    w_last_idx;

    assign cfg_ready   = (r_state_q != PENDING) && !cfg_abort;
    assign pending     = (r_state_q == PENDING);
    assign commit_done = r_commit_done_q;
    assign load_err    = r_load_err_q;
    assign w_last_idx  = (r_stage_q == C_LAST_STAGE) && (r_slot_q == C_LAST_SLOT);

    always_comb begin
        w_state_d    = r_state_q;
        w_stage_d    = r_stage_q;
        w_slot_d     = r_slot_q;
        w_wr_en      = 1'b0;
        w_commit     = 1'b0;
        w_load_err_d = 1'b0;

        if (cfg_abort) begin
            if (r_state_q != IDLE) begin
                w_state_d = IDLE;
                w_stage_d = '0;
                w_slot_d  = '0;
            end
        end else begin
            case (r_state_q)
                IDLE, LOAD: begin
                    if (cfg_valid) begin
                        w_wr_en = 1'b1;
                        if (w_last_idx && cfg_last) begin
                            w_state_d = PENDING;
                            w_stage_d = '0;
                            w_slot_d  = '0;
                        end else if (w_last_idx || cfg_last) begin
                            // Short or over-long set: drop it, active bank untouched.
                            w_load_err_d = 1'b1;
                            w_state_d    = IDLE;
                            w_stage_d    = '0;
                            w_slot_d     = '0;
                        end else begin
                            w_state_d = LOAD;
                            if (r_slot_q == C_LAST_SLOT) begin
                                w_slot_d  = '0;
                                w_stage_d = r_stage_q + 1'b1;
                            end else begin
                                w_slot_d  = r_slot_q + 1'b1;
                            end
                        end
                    end
                end
                PENDING: begin
                    if (sample_tick) begin
                        w_commit  = 1'b1;
                        w_state_d = IDLE;
                    end
                end
                default: begin
                    w_state_d = IDLE;
                    w_stage_d = '0;
                    w_slot_d  = '0;
                end
            endcase
        end
        w_commit_done_d = w_commit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= IDLE;
            r_stage_q       <= '0;
            r_slot_q        <= '0;
            r_commit_done_q <= 1'b0;
            r_load_err_q    <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_stage_q       <= w_stage_d;
            r_slot_q        <= w_slot_d;
            r_commit_done_q <= w_commit_done_d;
            r_load_err_q    <= w_load_err_d;
        end
    end

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        iir_coeff_bank #(
            .COEFF_W (COEFF_W),
            .UNITY   (UNITY)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_wr_en && (r_stage_q == C_STAGE_W'(s))),
            .i_wr_slot (r_slot_q),
            .i_wr_data (cfg_data),
            .i_commit  (w_commit),
            .o_b0      (coeff_b0[s*COEFF_W +: COEFF_W]),
            .o_b1      (coeff_b1[s*COEFF_W +: COEFF_W]),
            .o_b2      (coeff_b2[s*COEFF_W +: COEFF_W]),
            .o_a1      (coeff_a1[s*COEFF_W +: COEFF_W]),
            .o_a2      (coeff_a2[s*COEFF_W +: COEFF_W])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_iir_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir_coeff_loader
// Purpose  : Directed and randomized checks of the loader against a set-level model.
// Revision : 1.0
// ============================================================================
module tb_iir_coeff_loader;
    import iir_pkg::*;

    localparam int NS = 2;
    localparam int W  = 16;
    localparam int N  = 5 * NS;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_valid, cfg_ready, cfg_last, cfg_abort, sample_tick;
    logic [W-1:0]    cfg_data;
    logic [NS*W-1:0] coeff_b0, coeff_b1, coeff_b2, coeff_a1, coeff_a2;
    logic            pending, commit_done, load_err;

    iir_coeff_loader #(.NUM_STAGES(NS), .COEFF_W(W), .UNITY(16'h7FFF)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_last(cfg_last), .cfg_abort(cfg_abort),
        .sample_tick(sample_tick), .coeff_b0(coeff_b0), .coeff_b1(coeff_b1),
        .coeff_b2(coeff_b2), .coeff_a1(coeff_a1), .coeff_a2(coeff_a2),
        .pending(pending), .commit_done(commit_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    coeff_set_t    m_active [NS];
    logic [W-1:0]  m_words  [$];
    logic [W-1:0]  m_shadow [$];
    bit            m_pending, m_commit, m_err;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [NS*W-1:0] bus(int k);
        logic [NS*W-1:0] r = '0;
        for (int s = 0; s < NS; s++) begin
            case (k)
                0: r[s*W +: W] = m_active[s].b0;
                1: r[s*W +: W] = m_active[s].b1;
                2: r[s*W +: W] = m_active[s].b2;
                3: r[s*W +: W] = m_active[s].a1;
                default: r[s*W +: W] = m_active[s].a2;
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            m_active[s] = '{b0: 16'h7FFF, b1: 16'h0, b2: 16'h0, a1: 16'h0, a2: 16'h0};
        m_words.delete();
        m_shadow.delete();
        m_pending = 0;
        m_commit  = 0;
        m_err     = 0;
    endtask

    task automatic check_outputs();
        chk("coeff_b0",    coeff_b0,    bus(0));
        chk("coeff_b1",    coeff_b1,    bus(1));
        chk("coeff_b2",    coeff_b2,    bus(2));
        chk("coeff_a1",    coeff_a1,    bus(3));
        chk("coeff_a2",    coeff_a2,    bus(4));
        chk("pending",     pending,     m_pending);
        chk("commit_done", commit_done, m_commit);
        chk("load_err",    load_err,    m_err);
    endtask

    task automatic do_reset();
        rst = 1; cfg_valid = 0; cfg_data = '0; cfg_last = 0; cfg_abort = 0; sample_tick = 0;
        @(posedge clk); #1;
        model_reset();
        check_outputs();
        rst = 0;
        #1;
        chk("cfg_ready_after_reset", cfg_ready, 1'b1);
    endtask

    // One clock cycle: drive inputs, predict with the set-level model, compare after the edge.
    task automatic step(bit v, logic [W-1:0] d, bit l, bit a, bit t);
        cfg_valid = v; cfg_data = d; cfg_last = l; cfg_abort = a; sample_tick = t;
        #1;
        chk("cfg_ready", cfg_ready, !a && !m_pending);
        m_commit = 0;
        m_err    = 0;
        if (a) begin
            m_words.delete();
            m_pending = 0;
        end else if (m_pending) begin
            if (t) begin
                for (int s = 0; s < NS; s++)
                    m_active[s] = '{b0: m_shadow[5*s], b1: m_shadow[5*s+1], b2: m_shadow[5*s+2],
                                    a1: m_shadow[5*s+3], a2: m_shadow[5*s+4]};
                m_pending = 0;
                m_commit  = 1;
            end
        end else if (v) begin
            m_words.push_back(d);
            if (l || m_words.size() == N) begin
                if (l && m_words.size() == N) begin
                    m_shadow  = m_words;
                    m_pending = 1;
                end else begin
                    m_err = 1;
                end
                m_words.delete();
            end
        end
        @(posedge clk); #1;
        check_outputs();
    endtask

    task automatic send_set(int n, int last_at, logic [W-1:0] base, bit tick_on_last);
        for (int i = 0; i < n; i++)
            step(1, base + W'(i), (i == last_at), 0, tick_on_last && (i == n - 1));
    endtask

    task automatic idle(int n, bit t);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, t);
    endtask

    initial begin
        do_reset();
        chk("reset_b0_unity", coeff_b0, 32'h7FFF_7FFF);
        chk("reset_pending",  pending,  1'b0);

        // Well-formed set held until a tick arrives.
        send_set(N, N - 1, 16'h1000, 0);
        idle(3, 0);
        chk("pending_held", pending, 1'b1);
        step(0, '0, 0, 0, 1);
        chk("commit_b0", coeff_b0, 32'h1005_1000);
        chk("commit_a2", coeff_a2, 32'h1009_1004);
        idle(1, 0);

        // Short set, then a good set.
        send_set(7, 6, 16'h2000, 0);
        idle(1, 0);
        send_set(N, N - 1, 16'h3000, 0);
        step(0, '0, 0, 0, 1);
        chk("commit2_b1", coeff_b1, 32'h3006_3001);

        // Missing cfg_last on the final word.
        send_set(N, -1, 16'h4000, 0);
        idle(2, 1);

        // Tick coincident with the last word does not commit.
        send_set(N, N - 1, 16'h5000, 1);
        idle(1, 0);
        step(0, '0, 0, 0, 1);

        // Abort beats tick in PENDING.
        send_set(N, N - 1, 16'h6000, 0);
        step(1, 16'hDEAD, 0, 1, 1);
        idle(1, 1);

        // Reset mid-load, then a fresh set from index 0.
        send_set(4, -1, 16'h7000, 0);
        do_reset();
        send_set(N, N - 1, 16'h8000, 0);
        step(0, '0, 0, 0, 1);
        chk("post_reset_a1", coeff_a1, 32'h8008_8003);

        // Abort in IDLE and mid-load.
        step(1, 16'h1111, 0, 1, 0);
        send_set(3, -1, 16'h9000, 0);
        step(0, '0, 0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit v, l, a, t;
            v = ($urandom_range(0, 3) != 0);
            l = (m_words.size() == N - 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 30) == 0);
            a = ($urandom_range(0, 40) == 0);
            t = ($urandom_range(0, 4) == 0);
            step(v, W'($urandom), l, a, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iir_coeff_loader.md
Name: iir_coeff_loader

Overview:
- Coefficient-side counterpart to the biquad stage: owns and drives the coeff_b0/b1/b2/a1/a2 inputs of a cascade of NUM_STAGES biquads.
- Accepts a word-serial configuration stream over a valid/ready handshake into a shadow bank.
- Commits shadow to active atomically on a sample boundary, so no stage ever filters with a mixed coefficient set.
- Sits between the control/config fabric and the filter cascade.

Parameters:
- NUM_STAGES, 2, number of biquad stages served (1..8).
- COEFF_W, 16, coefficient width, signed Q1.15.
- UNITY, 16'h7FFF, reset value of every b0 (pass-through).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config word valid.
- cfg_ready  out  1  loader can accept a word.
- cfg_data  in  COEFF_W  config word.
- cfg_last  in  1  marks the final word of a set.
- cfg_abort  in  1  discard the load in progress or pending.
- sample_tick  in  1  one-cycle strobe at a sample boundary; the commit point.
- coeff_b0  out  NUM_STAGES*COEFF_W  active b0; stage s occupies bits [s*COEFF_W +: COEFF_W].
- coeff_b1, coeff_b2, coeff_a1, coeff_a2  out  NUM_STAGES*COEFF_W  same packing.
- pending  out  1  a complete shadow set is waiting for commit.
- commit_done  out  1  one-cycle pulse: active bank updated.
- load_err  out  1  one-cycle pulse: malformed set discarded.

Behaviour:
- Reset (rst high at a clk edge):
  - Every active and shadow b0 = UNITY; all b1, b2, a1, a2 = 0.
  - FSM = IDLE; word index = 0; pending, commit_done, load_err = 0.
  - rst has priority over everything, including mid-load and mid-commit.
- Word order per set: stage0 b0, b1, b2, a1, a2, then stage1 b0 ... A set is exactly N = 5*NUM_STAGES words.
- A word transfers when cfg_valid and cfg_ready are both high at a clk edge. It is written to the shadow slot selected by the word index; the index increments.
- FSM states: IDLE, LOAD, PENDING.
  - IDLE: cfg_ready = 1. An accepted word goes to LOAD (index becomes 1).
  - LOAD: cfg_ready = 1.
    - Accepted word with index == N-1 and cfg_last = 1: go to PENDING.
    - Accepted word with cfg_last = 1 and index < N-1: load_err pulse, go to IDLE.
    - Accepted word with index == N-1 and cfg_last = 0: load_err pulse, go to IDLE.
  - PENDING: cfg_ready = 0; pending = 1.
    - sample_tick = 1 at a clk edge: all active outputs take the shadow values on that edge, commit_done = 1 for the next cycle, go to IDLE.
- Error case: the index resets to 0 and active outputs are unchanged. The shadow contents are don't-care and are never committed.
- Shadow-to-active copy is a single-edge, full-bank update. All 5*NUM_STAGES active registers change on the same edge.
- Active outputs are registers only; there is no combinational path from cfg_* or sample_tick to coeff_*.
- cfg_abort (priority below rst, above everything else):
  - In LOAD or PENDING: go to IDLE, index = 0, no commit, no load_err.
  - In IDLE: no effect.
  - A word presented in the abort cycle is not accepted: cfg_ready = 0 while cfg_abort = 1.
- Simultaneous events:
  - sample_tick in the same cycle the last word is accepted: no commit. A commit needs PENDING at the start of the cycle.
  - sample_tick in IDLE or LOAD: ignored.
  - cfg_abort together with sample_tick in PENDING: abort wins, no commit.
- NUM_STAGES = 1 is legal: N = 5.
- Latency: from the last word accepted to coeffs updated is at least 1 tick edge. From the tick edge to new outputs is 0 cycles (same edge).

Decomposition:
- Package iir_pkg holds:
  - the COEFF_W default and the UNITY constant;
  - a coeff_set_t packed struct {b0, b1, b2, a1, a2};
  - a loader_state_t enum {IDLE, LOAD, PENDING};
  - a COEFFS_PER_STAGE = 5 constant.
- One sub-module, iir_coeff_bank: the shadow/active register pair for one stage. It is generated NUM_STAGES times and holds a write-enable + slot index for the shadow, plus a commit strobe.

Test Plan:
- Reset with NUM_STAGES=2 -> every b0 slice = 16'h7FFF, all other coeffs 0, cfg_ready=1, pending=0.
- Stream 10 words 16'h1000..16'h1009 with cfg_last on word 10, no tick -> outputs stay at reset values, pending=1, cfg_ready=0. Then tick -> same edge: stage0 b0=1000, b1=1001, b2=1002, a1=1003, a2=1004; stage1 b0=1005 ... a2=1009; commit_done pulses once.
- cfg_last on word 7 -> load_err pulses once, FSM returns to IDLE, active coeffs unchanged. A following well-formed 10-word set then commits normally.
- Word 10 sent with cfg_last=0 -> load_err pulses, no pending.
- sample_tick asserted in the same cycle as the final word -> no commit that cycle; commit occurs on the next tick.
- cfg_abort in PENDING concurrent with sample_tick -> no commit, pending=0, cfg_ready=1 next cycle.
- rst asserted after 4 words of a set -> all outputs at reset values. A fresh full set loads from index 0 and commits correctly.
